// File: rtl/ip_uart_rx_inst.sv
// Z80 I/O-mapped UART receiver.
// Deserialises 8N1 frames from uart_rx into an 8-entry receive FIFO.
// The data port (io_address+0) pops received bytes and the status/control
// port (io_address+1) reports and clears receiver state and flushes the FIFO.
module ip_uart_rx_inst #(
    parameter int unsigned clk_freq   = 86400000,
    parameter int unsigned uart_freq  = 115200,
    parameter logic [7:0]  io_address = 8'h10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] a,
    input  logic [7:0] d,
    output logic [7:0] q,
    output logic       q_en,
    input  logic       uart_rx
);

    localparam int unsigned BIT_CLKS  = clk_freq / uart_freq;
    localparam int unsigned HALF_CLKS = BIT_CLKS >> 1;
    localparam int          CW        = $clog2(BIT_CLKS + 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(BIT_CLKS);
    localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_CLKS);
    localparam logic [7:0]  DATA_ADDR = {io_address[7:1], 1'b0};
    localparam logic [7:0]  STAT_ADDR = {io_address[7:1], 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_t;

    // Line synchroniser and edge detection
    logic          rx_meta_r, rx_sync_r, rx_prev_r;
    logic          fall_s;

    // Receiver FSM and datapath
    rx_state_t     state_r, state_nx_s;
    logic [CW-1:0] baud_cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          expire_s;
    logic          load_half_s, load_full_s, shift_s, clr_idx_s;
    logic          rx_push_s, set_ovr_s, set_ferr_s, busy_s;

    // FIFO
    logic [7:0]    mem_r [8];
    logic [2:0]    wr_ptr_r, rd_ptr_r;
    logic [3:0]    count_r;
    logic          empty_s, full_s, pop_s, do_push_s, do_pop_s;

    // Bus side
    logic          data_rd_s, stat_rd_s, stat_wr_s;
    logic          rd_data_r, rd_data_d_r, rd_hit_r;
    logic          wr_r, wr_d_r, wr_act_s;
    logic [7:0]    wr_data_r;
    logic          flush_s, clr_ovr_s, clr_ferr_s;
    logic          ovr_r, ferr_r;
    logic [7:0]    status_s;

    assign fall_s   = rx_prev_r & ~rx_sync_r;
    assign expire_s = (baud_cnt_r == CW'(1));
    assign empty_s  = (count_r == 4'd0);
    assign full_s   = (count_r == 4'd8);

    assign data_rd_s = ~iorq_n & ~rd_n & (a == DATA_ADDR);
    assign stat_rd_s = ~iorq_n & ~rd_n & (a == STAT_ADDR);
    assign stat_wr_s = ~iorq_n & ~wr_n & (a == STAT_ADDR);

    // Pop only once the read has ended, and only if the read showed a real byte
    assign pop_s      = rd_data_d_r & ~rd_data_r & rd_hit_r;
    assign wr_act_s   = wr_r & ~wr_d_r;
    assign flush_s    = wr_act_s & wr_data_r[7];
    assign clr_ovr_s  = wr_act_s & wr_data_r[2];
    assign clr_ferr_s = wr_act_s & wr_data_r[3];
    assign do_push_s  = rx_push_s & ~flush_s;
    assign do_pop_s   = pop_s & ~empty_s & ~flush_s;

    assign status_s = {3'b000, busy_s, ferr_r, ovr_r, full_s, ~empty_s};

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Receiver FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Receiver FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) state_nx_s = ST_START;
                else        state_nx_s = ST_IDLE;
            end
            ST_START: begin
                if (expire_s) state_nx_s = rx_sync_r ? ST_IDLE : ST_DATA;
                else          state_nx_s = ST_START;
            end
            ST_DATA: begin
                if (expire_s && (bit_idx_r == 3'd7)) state_nx_s = ST_STOP;
                else                                 state_nx_s = ST_DATA;
            end
            ST_STOP: begin
                if (expire_s) state_nx_s = rx_sync_r ? ST_IDLE : ST_WAIT_HIGH;
                else          state_nx_s = ST_STOP;
            end
            ST_WAIT_HIGH: begin
                if (rx_sync_r) state_nx_s = ST_IDLE;
                else           state_nx_s = ST_WAIT_HIGH;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Receiver FSM control outputs
    always_comb begin
        load_half_s = 1'b0;
        load_full_s = 1'b0;
        shift_s     = 1'b0;
        clr_idx_s   = 1'b0;
        rx_push_s   = 1'b0;
        set_ovr_s   = 1'b0;
        set_ferr_s  = 1'b0;
        busy_s      = (state_r != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                load_half_s = fall_s;
            end
            ST_START: begin
                if (expire_s && !rx_sync_r) begin
                    load_full_s = 1'b1;
                    clr_idx_s   = 1'b1;
                end else begin
                    load_full_s = 1'b0;
                end
            end
            ST_DATA: begin
                if (expire_s) begin
                    shift_s     = 1'b1;
                    load_full_s = 1'b1;
                end else begin
                    shift_s     = 1'b0;
                end
            end
            ST_STOP: begin
                if (expire_s) begin
                    if (rx_sync_r) begin
                        // A pop in the same clock frees the slot for this byte
                        if (!full_s || pop_s) rx_push_s = 1'b1;
                        else                  set_ovr_s = 1'b1;
                    end else begin
                        set_ferr_s = 1'b1;
                    end
                end else begin
                    rx_push_s = 1'b0;
                end
            end
            ST_WAIT_HIGH: begin
                rx_push_s = 1'b0;
            end
            default: begin
                rx_push_s = 1'b0;
            end
        endcase
    end

    // Baud counter, bit index and LSB-first shift register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baud_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
        end else begin
            if (load_half_s)             baud_cnt_r <= HALF_LOAD;
            else if (load_full_s)        baud_cnt_r <= BIT_LOAD;
            else if (baud_cnt_r != '0)   baud_cnt_r <= baud_cnt_r - CW'(1);
            else                         baud_cnt_r <= baud_cnt_r;

            if (clr_idx_s)    bit_idx_r <= 3'd0;
            else if (shift_s) bit_idx_r <= bit_idx_r + 3'd1;
            else              bit_idx_r <= bit_idx_r;

            if (shift_s) shift_r <= {rx_sync_r, shift_r[7:1]};
            else         shift_r <= shift_r;
        end
    end

    // FIFO storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) mem_r[i] <= 8'h00;
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= shift_r;
        end
    end

    // FIFO pointers and occupancy; flush overrides push and pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= 3'd0;
            rd_ptr_r <= 3'd0;
            count_r  <= 4'd0;
        end else if (flush_s) begin
            wr_ptr_r <= 3'd0;
            rd_ptr_r <= 3'd0;
            count_r  <= 4'd0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + 3'd1;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 3'd1;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 4'd1;
                2'b01:   count_r <= count_r - 4'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error flags; a new error outranks a clear in the same clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovr_r  <= 1'b0;
            ferr_r <= 1'b0;
        end else begin
            if (set_ovr_s)      ovr_r <= 1'b1;
            else if (clr_ovr_s) ovr_r <= 1'b0;
            else                ovr_r <= ovr_r;

            if (set_ferr_s)      ferr_r <= 1'b1;
            else if (clr_ferr_s) ferr_r <= 1'b0;
            else                 ferr_r <= ferr_r;
        end
    end

    // Registered read mux and read-end tracking for the deferred pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q           <= 8'h00;
            q_en        <= 1'b0;
            rd_data_r   <= 1'b0;
            rd_data_d_r <= 1'b0;
            rd_hit_r    <= 1'b0;
        end else begin
            q_en        <= data_rd_s | stat_rd_s;
            rd_data_r   <= data_rd_s;
            rd_data_d_r <= rd_data_r;
            if (data_rd_s) begin
                q        <= empty_s ? 8'hFF : mem_r[rd_ptr_r];
                rd_hit_r <= ~empty_s;
            end else if (stat_rd_s) begin
                q        <= status_s;
                rd_hit_r <= rd_hit_r;
            end else begin
                q        <= 8'h00;
                rd_hit_r <= rd_hit_r;
            end
        end
    end

    // Status-port write capture; acts once per write cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_r      <= 1'b0;
            wr_d_r    <= 1'b0;
            wr_data_r <= 8'h00;
        end else begin
            wr_r   <= stat_wr_s;
            wr_d_r <= wr_r;
            if (stat_wr_s) wr_data_r <= d;
            else           wr_data_r <= wr_data_r;
        end
    end

endmodule

// File: tb/tb_ip_uart_rx_inst.sv
// Self-checking bench for ip_uart_rx_inst: directed scenarios plus a random
// phase, checked against a queue-based model of the receive FIFO and flags.
module tb_ip_uart_rx_inst;

    localparam int BIT = 20;

    logic       clk = 1'b0;
    logic       reset_n, iorq_n, rd_n, wr_n, uart_rx, q_en;
    logic [7:0] a, d, q;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] model_q[$];
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;

    always #5 clk = ~clk;

    ip_uart_rx_inst #(
        .clk_freq   (2000),
        .uart_freq  (100),
        .io_address (8'h10)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .iorq_n  (iorq_n),
        .rd_n    (rd_n),
        .wr_n    (wr_n),
        .a       (a),
        .d       (d),
        .q       (q),
        .q_en    (q_en),
        .uart_rx (uart_rx)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] model_status();
        logic full, ready;
        full  = (model_q.size() == 8);
        ready = (model_q.size() != 0);
        return {3'b000, 1'b0, m_ferr, m_ovr, full, ready};
    endfunction

    task automatic model_push(input logic [7:0] b);
        if (model_q.size() < 8) model_q.push_back(b);
        else m_ovr = 1'b1;
    endtask

    task automatic io_read(input logic [7:0] addr, output logic [7:0] data);
        @(negedge clk);
        a = addr; iorq_n = 1'b0; rd_n = 1'b0;
        repeat (2) @(negedge clk);
        check_val("q_en", q_en, 1'b1);
        data = q;
        rd_n = 1'b1; iorq_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        a = addr; d = data; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (2) @(negedge clk);
        wr_n = 1'b1; iorq_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic rd_data(input string tag);
        logic [7:0] v, e;
        io_read(8'h10, v);
        e = (model_q.size() != 0) ? model_q.pop_front() : 8'hFF;
        check_val(tag, v, e);
    endtask

    task automatic rd_status(input string tag);
        logic [7:0] v;
        io_read(8'h11, v);
        check_val(tag, v, model_status());
    endtask

    // Drives one complete 8N1 frame; the caller updates the model
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (BIT + 4) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] v, b, x, z;
        reset_n = 1'b0; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        a = 8'h00; d = 8'h00; uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_q", q, 8'h00);
        check_val("rst_q_en", q_en, 1'b0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        rd_status("rst_status");
        rd_data("rst_empty_read");

        // Single byte
        send_byte(8'hA5); model_push(8'hA5);
        check_val("a5_status", model_status(), 8'h01);
        rd_status("a5_status_dut");
        rd_data("a5_data");
        rd_status("a5_status_after");

        // Overrun: nine bytes, no reads
        for (int i = 1; i <= 9; i++) begin
            b = 8'(i);
            send_byte(b); model_push(b);
        end
        rd_status("ovr_status");
        for (int i = 0; i < 9; i++) rd_data("ovr_drain");
        io_write(8'h11, 8'h04); m_ovr = 1'b0;
        rd_status("ovr_cleared");

        // Framing error: stop bit held low for two bit times
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            x = 8'h3C;
            uart_rx = x[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rx = 1'b0;
        repeat (15) @(negedge clk);
        m_ferr = 1'b1;
        io_read(8'h11, v);
        check_val("ferr_busy", v, model_status() | 8'h10);
        repeat (2 * BIT - 21) @(negedge clk);
        uart_rx = 1'b1;
        repeat (6) @(negedge clk);
        rd_status("ferr_idle");
        rd_data("ferr_no_push");
        io_write(8'h11, 8'h08); m_ferr = 1'b0;
        rd_status("ferr_cleared");

        // Glitch shorter than half a bit
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (5) @(negedge clk);
        uart_rx = 1'b1;
        io_read(8'h11, v);
        check_val("glitch_busy", v, 8'h10);
        repeat (BIT) @(negedge clk);
        rd_status("glitch_idle");
        rd_data("glitch_no_push");

        // Flush
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 255));
            send_byte(b); model_push(b);
        end
        io_write(8'h11, 8'h80); model_q.delete();
        rd_status("flush_status");
        rd_data("flush_read");

        // Read completion swept around the push clock
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom_range(0, 255));
            send_byte(b); model_push(b);
        end
        for (int k = 0; k < 7; k++) begin
            z = 8'($urandom_range(0, 255));
            fork
                send_byte(z);
                begin
                    repeat (186 + k) @(negedge clk);
                    rd_data("coinc_read");
                end
            join
            model_push(z);
            rd_status("coinc_status");
        end
        while (model_q.size() != 0) rd_data("coinc_drain");
        rd_data("coinc_empty");

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: begin
                    b = 8'($urandom_range(0, 255));
                    send_byte(b); model_push(b);
                end
                3:       rd_data("rand_data");
                4:       rd_status("rand_status");
                default: begin
                    io_write(8'h11, 8'h04); m_ovr = 1'b0;
                end
            endcase
        end
        rd_status("rand_final_status");

        // Reset during data bit 4
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom_range(0, 255));
            send_byte(b); model_push(b);
        end
        x = 8'h5A;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rx = x[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rx = x[4];
        repeat (BIT / 2) @(negedge clk);
        reset_n = 1'b0;
        uart_rx = 1'b1;
        model_q.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
        repeat (2) @(negedge clk);
        check_val("midrst_q", q, 8'h00);
        check_val("midrst_q_en", q_en, 1'b0);
        reset_n = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        rd_status("midrst_status");
        rd_data("midrst_data");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
